schedule_controller: RTL

Weekly setpoint scheduler for the thermostat. Holds a small programmable table of schedule entries (day mask, start time, target temperature), rescans the table each time the time keeper's minute changes, and drives the active target temperature to the HVAC control logic. Sits between the time keeper outputs and the temperature control loop; entries are written by the user-interface block.

---
 rtl/sched_pkg.sv | 41 ++++
 rtl/schedule_entry_table.sv | 77 +++++++
 rtl/schedule_controller.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sched_pkg
//  Description : Shared field widths, limits, FSM encoding and entry layout
//                for the weekly setpoint scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package sched_pkg;

  localparam int DAY_W  = 7;
  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int TEMP_W = 7;
  localparam int KEY_W  = HOUR_W + MIN_W;

  localparam logic [HOUR_W-1:0] HOUR_MAX     = 5'd23;
  localparam logic [MIN_W-1:0]  MIN_MAX      = 6'd59;
  localparam logic [TEMP_W-1:0] DEFAULT_TEMP = 7'd68;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_UPDATE = 2'd2
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [DAY_W-1:0]  day_mask;
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  minute;
    logic [TEMP_W-1:0] temp;
  } entry_t;

  // Hour in the upper bits makes the packed key order match time of day.
  function automatic logic [KEY_W-1:0] make_key(input logic [HOUR_W-1:0] hour,
                                                input logic [MIN_W-1:0]  minute);
    return {hour, minute};
  endfunction

endpackage
`default_nettype wire

// File: rtl/schedule_entry_table.sv
`default_nettype none
// ============================================================================
//  Module      : schedule_entry_table
//  Description : Schedule entry register file. Validates each write strobe,
//                stores legal writes, flags illegal ones one cycle later and
//                provides a combinational read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module schedule_entry_table
  import sched_pkg::*;
#(
  parameter int g_num_entries = 4,
  parameter int g_idx_width   = 2
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_wr_en,
  input  logic [g_idx_width-1:0] i_wr_idx,
  input  logic [DAY_W-1:0]       i_wr_day_mask,
  input  logic [HOUR_W-1:0]      i_wr_hour,
  input  logic [MIN_W-1:0]       i_wr_minute,
  input  logic [TEMP_W-1:0]      i_wr_temp,
  input  logic                   i_wr_valid,
  input  logic [g_idx_width-1:0] i_rd_idx,
  output entry_t                 o_rd_entry,
  output logic                   o_wr_accept,
  output logic                   o_wr_err
);

  entry_t r_table [g_num_entries];
  logic   r_wr_err;
  logic   w_wr_legal;
  logic   w_rd_in_range;
  entry_t w_wr_data;

  // Index check is kept generic so non power-of-two table sizes stay safe.
  assign w_wr_legal = (i_wr_hour <= HOUR_MAX) && (i_wr_minute <= MIN_MAX) &&
                      (32'(i_wr_idx) < 32'(g_num_entries));
  assign o_wr_accept = i_wr_en && w_wr_legal;

  assign w_wr_data = '{valid:    i_wr_valid,
                       day_mask: i_wr_day_mask,
                       hour:     i_wr_hour,
                       minute:   i_wr_minute,
                       temp:     i_wr_temp};

  // Table storage: cleared on reset, one entry written per accepted strobe.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < g_num_entries; i++) begin
        r_table[i] <= '0;
      end
    end else if (o_wr_accept) begin
      for (int i = 0; i < g_num_entries; i++) begin
        if (32'(i_wr_idx) == 32'(i)) begin
          r_table[i] <= w_wr_data;
        end
      end
    end
  end

  // Rejected strobes report one cycle after the attempt.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_err <= 1'b0;
    end else begin
      r_wr_err <= i_wr_en && !w_wr_legal;
    end
  end

  assign o_wr_err = r_wr_err;

  assign w_rd_in_range = 32'(i_rd_idx) < 32'(g_num_entries);
  assign o_rd_entry    = w_rd_in_range ? r_table[i_rd_idx] : '0;

endmodule
`default_nettype wire

// File: rtl/schedule_controller.sv
`default_nettype none
// ============================================================================
//  Module      : schedule_controller
//  Description : Weekly setpoint scheduler. Rescans the entry table whenever
//                the time or the table changes and drives the setpoint of the
//                latest entry of today that has already started.
//  Revision    : 1.0 - initial release
// ============================================================================
module schedule_controller
  import sched_pkg::*;
#(
  parameter int g_num_entries  = 4,
  parameter int g_idx_width    = 2,
  parameter int g_default_temp = 68
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic [DAY_W-1:0]       i_day,
  input  logic [HOUR_W-1:0]      i_hour,
  input  logic [MIN_W-1:0]       i_minute,
  input  logic                   i_wr_en,
  input  logic [g_idx_width-1:0] i_wr_idx,
  input  logic [DAY_W-1:0]       i_wr_day_mask,
  input  logic [HOUR_W-1:0]      i_wr_hour,
  input  logic [MIN_W-1:0]       i_wr_minute,
  input  logic [TEMP_W-1:0]      i_wr_temp,
  input  logic                   i_wr_valid,
  output logic [TEMP_W-1:0]      o_setpoint,
  output logic [g_idx_width-1:0] o_active_idx,
  output logic                   o_match,
  output logic                   o_busy,
  output logic                   o_wr_err
);

  localparam logic [TEMP_W-1:0]      c_default_temp = TEMP_W'(g_default_temp);
  localparam logic [g_idx_width-1:0] c_last_idx     = g_idx_width'(g_num_entries - 1);

  state_t                 r_state;
  logic [g_idx_width-1:0] r_idx;
  logic                   r_scan_pending;
  logic [DAY_W-1:0]       r_last_day;
  logic [HOUR_W-1:0]      r_last_hour;
  logic [MIN_W-1:0]       r_last_min;
  logic                   r_found;
  logic [KEY_W-1:0]       r_best_key;
  logic [TEMP_W-1:0]      r_best_temp;
  logic [g_idx_width-1:0] r_best_idx;

  entry_t                 w_entry;
  logic                   w_wr_accept;
  logic                   w_time_change;
  logic                   w_scan_event;
  logic [KEY_W-1:0]       w_entry_key;
  logic [KEY_W-1:0]       w_now_key;
  logic                   w_candidate;
  logic                   w_better;

  schedule_entry_table #(
    .g_num_entries (g_num_entries),
    .g_idx_width   (g_idx_width)
  ) u_table (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_wr_en       (i_wr_en),
    .i_wr_idx      (i_wr_idx),
    .i_wr_day_mask (i_wr_day_mask),
    .i_wr_hour     (i_wr_hour),
    .i_wr_minute   (i_wr_minute),
    .i_wr_temp     (i_wr_temp),
    .i_wr_valid    (i_wr_valid),
    .i_rd_idx      (r_idx),
    .o_rd_entry    (w_entry),
    .o_wr_accept   (w_wr_accept),
    .o_wr_err      (o_wr_err)
  );

  // Any change of day, hour or minute invalidates the current result, so a
  // mid-scan change of the live time inputs also forces a rescan.
  assign w_time_change = (i_minute != r_last_min) || (i_hour != r_last_hour) ||
                         (i_day != r_last_day);
  assign w_scan_event  = w_time_change || w_wr_accept;

  assign w_entry_key = make_key(w_entry.hour, w_entry.minute);
  assign w_now_key   = make_key(i_hour, i_minute);
  assign w_candidate = w_entry.valid && (|(w_entry.day_mask & i_day)) &&
                       (w_entry_key <= w_now_key);
  // Strictly greater only: equal keys keep the lower index found first.
  assign w_better    = w_candidate && (!r_found || (w_entry_key > r_best_key));

  // Previous time sample used for change detection.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_last_day  <= '0;
      r_last_hour <= '0;
      r_last_min  <= '0;
    end else begin
      r_last_day  <= i_day;
      r_last_hour <= i_hour;
      r_last_min  <= i_minute;
    end
  end

  // Scan FSM with best-candidate tracking and registered outputs. A change
  // seen in IDLE starts the scan on the very next edge; events during a scan
  // are folded into a single pending follow-up scan.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state        <= ST_IDLE;
      r_idx          <= '0;
      r_scan_pending <= 1'b1;
      r_found        <= 1'b0;
      r_best_key     <= '0;
      r_best_temp    <= '0;
      r_best_idx     <= '0;
      o_setpoint     <= c_default_temp;
      o_active_idx   <= '0;
      o_match        <= 1'b0;
      o_busy         <= 1'b0;
    end else begin
      if (w_scan_event) begin
        r_scan_pending <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (r_scan_pending || w_scan_event) begin
            r_scan_pending <= 1'b0;
            r_state        <= ST_SCAN;
            r_idx          <= '0;
            r_found        <= 1'b0;
            r_best_key     <= '0;
            r_best_temp    <= '0;
            r_best_idx     <= '0;
            o_busy         <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (w_better) begin
            r_found     <= 1'b1;
            r_best_key  <= w_entry_key;
            r_best_temp <= w_entry.temp;
            r_best_idx  <= r_idx;
          end
          if (r_idx == c_last_idx) begin
            r_state <= ST_UPDATE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_UPDATE: begin
          // No match keeps the old setpoint so it carries over midnight.
          if (r_found) begin
            o_setpoint   <= r_best_temp;
            o_active_idx <= r_best_idx;
          end
          o_match <= r_found;
          o_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
